// File: rtl/multiboot_ctrl.sv
// Multiboot controller: picks a flash image (button at power-on or run-time request) and
// streams the 9-word ICAP reboot sequence on a divided clock. MBT_BITSWAP_EN bit-reverses each byte.
module multiboot_ctrl #(
    parameter int          CLK_DIV    = 50,
    parameter int          NUM_IMAGES = 4,
    parameter logic [23:0] IMG_BASE   = 24'h000000,
    parameter logic [23:0] IMG_STRIDE = 24'h020000,
    parameter int          BTN_IMG    = 1,
    parameter logic [7:0]  READ_OP    = 8'h0B
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUTTON,
    input  logic        REQ,
    input  logic [3:0]  IMG_SEL,
    output logic        ICAP_CLK,
    output logic        ICAP_CE,
    output logic        ICAP_WRITE,
    output logic [15:0] ICAP_O,
    output logic        BUSY,
    output logic        ERR
);

    localparam int               DIV_W   = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_DIV);
    localparam logic [4:0]       NUM_IMG = 5'(NUM_IMAGES);
    localparam logic [3:0]       BTN_IDX = 4'(BTN_IMG);

    typedef enum logic [2:0] {
        S_POR,
        S_IDLE,
        S_ARM,
        S_SEND,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             icap_clk_q;
    logic [3:0]       widx_q;
    logic [23:0]      addr_q;
    logic [15:0]      icap_o_q;
    logic             ce_q;
    logic             we_q;
    logic             busy_q;
    logic             err_q;
    logic             div_tc;
    logic             fall_tick;
    logic             sel_ok;

    function automatic logic [23:0] img_addr(input logic [3:0] idx);
        // Wraps modulo 2^24 by construction of the 24-bit result.
        return IMG_BASE + 24'(idx) * IMG_STRIDE;
    endfunction

    function automatic logic [15:0] seq_word(input logic [3:0] w, input logic [23:0] a);
        logic [15:0] v;
        case (w)
            4'd0:    v = 16'hFFFF;
            4'd1:    v = 16'hAA99;
            4'd2:    v = 16'h3261;
            4'd3:    v = a[15:0];
            4'd4:    v = 16'h3281;
            4'd5:    v = {READ_OP, a[23:16]};
            4'd6:    v = 16'h30A1;
            4'd7:    v = 16'h000E;
            4'd8:    v = 16'h2000;
            default: v = 16'hFFFF;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] wire_word(input logic [3:0] w, input logic [23:0] a);
        logic [15:0] raw;
        logic [15:0] out;
        raw = seq_word(w, a);
`ifdef MBT_BITSWAP_EN
        for (int b = 0; b < 8; b++) begin
            out[b]     = raw[7 - b];
            out[8 + b] = raw[15 - b];
        end
`else
        out = raw;
`endif
        return out;
    endfunction

    always_comb begin
        div_tc    = (div_q == DIV_TC);
        div_d     = div_tc ? '0 : div_q + DIV_W'(1);
        fall_tick = div_tc && icap_clk_q;
        sel_ok    = ({1'b0, IMG_SEL} < NUM_IMG);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_POR;
            div_q      <= '0;
            icap_clk_q <= 1'b0;
            widx_q     <= 4'd0;
            addr_q     <= 24'h000000;
            icap_o_q   <= 16'hFFFF;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            div_q <= div_d;
            if (div_tc) begin
                icap_clk_q <= ~icap_clk_q;
            end
            err_q <= 1'b0;

            case (state_q)
                S_POR: begin
                    // Button is active-low and is only looked at here, once per reset.
                    if (!BUTTON) begin
                        addr_q  <= img_addr(BTN_IDX);
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (REQ) begin
                        if (sel_ok) begin
                            addr_q  <= img_addr(IMG_SEL);
                            busy_q  <= 1'b1;
                            state_q <= S_ARM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (fall_tick) begin
                        widx_q   <= 4'd0;
                        icap_o_q <= wire_word(4'd0, addr_q);
                        ce_q     <= 1'b0;
                        we_q     <= 1'b0;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Data only moves on falling ticks so ICAP sees it stable around its rising edge.
                    if (fall_tick) begin
                        if (widx_q == 4'd8) begin
                            icap_o_q <= 16'hFFFF;
                            ce_q     <= 1'b1;
                            we_q     <= 1'b1;
                            state_q  <= S_HOLD;
                        end else begin
                            widx_q   <= widx_q + 4'd1;
                            icap_o_q <= wire_word(widx_q + 4'd1, addr_q);
                        end
                    end
                end
                S_HOLD: begin
                    state_q <= S_HOLD;
                end
                default: begin
                    state_q <= S_POR;
                end
            endcase
        end
    end

    assign ICAP_CLK   = icap_clk_q;
    assign ICAP_CE    = ce_q;
    assign ICAP_WRITE = we_q;
    assign ICAP_O     = icap_o_q;
    assign BUSY       = busy_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Directed bench for multiboot_ctrl: button boot, run-time request, rejection, address wrap,
// and asynchronous reset mid-sequence. Expected words follow MBT_BITSWAP_EN when defined.
module tb_multiboot_ctrl;

    localparam int CDIV = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        BUTTON;
    logic        REQ;
    logic [3:0]  IMG_SEL;
    logic [3:0]  IMG_SEL2;
    logic        ICAP_CLK, ICAP_CE, ICAP_WRITE, BUSY, ERR;
    logic [15:0] ICAP_O;
    logic        ICAP_CLK2, ICAP_CE2, ICAP_WRITE2, BUSY2, ERR2;
    logic [15:0] ICAP_O2;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    multiboot_ctrl #(
        .CLK_DIV(CDIV), .NUM_IMAGES(4), .IMG_BASE(24'h000000),
        .IMG_STRIDE(24'h020000), .BTN_IMG(1), .READ_OP(8'h0B)
    ) dut (
        .CLK(CLK), .RST(RST), .BUTTON(BUTTON), .REQ(REQ), .IMG_SEL(IMG_SEL),
        .ICAP_CLK(ICAP_CLK), .ICAP_CE(ICAP_CE), .ICAP_WRITE(ICAP_WRITE),
        .ICAP_O(ICAP_O), .BUSY(BUSY), .ERR(ERR)
    );

    multiboot_ctrl #(
        .CLK_DIV(CDIV), .NUM_IMAGES(4), .IMG_BASE(24'hFF0000),
        .IMG_STRIDE(24'h020000), .BTN_IMG(1), .READ_OP(8'h0B)
    ) dut_wrap (
        .CLK(CLK), .RST(RST), .BUTTON(BUTTON), .REQ(REQ), .IMG_SEL(IMG_SEL2),
        .ICAP_CLK(ICAP_CLK2), .ICAP_CE(ICAP_CE2), .ICAP_WRITE(ICAP_WRITE2),
        .ICAP_O(ICAP_O2), .BUSY(BUSY2), .ERR(ERR2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input int w, input logic [23:0] a);
        logic [15:0] v;
        logic [15:0] s;
        case (w)
            0: v = 16'hFFFF;
            1: v = 16'hAA99;
            2: v = 16'h3261;
            3: v = a[15:0];
            4: v = 16'h3281;
            5: v = {8'h0B, a[23:16]};
            6: v = 16'h30A1;
            7: v = 16'h000E;
            8: v = 16'h2000;
            default: v = 16'hFFFF;
        endcase
`ifdef MBT_BITSWAP_EN
        for (int b = 0; b < 8; b++) begin
            s[b]     = v[7 - b];
            s[8 + b] = v[15 - b];
        end
`else
        s = v;
`endif
        return s;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_icap_clk"}, 32'(ICAP_CLK), 32'd0);
        check({tag, "_ce"}, 32'(ICAP_CE), 32'd1);
        check({tag, "_write"}, 32'(ICAP_WRITE), 32'd1);
        check({tag, "_o"}, 32'(ICAP_O), 32'hFFFF);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_err"}, 32'(ERR), 32'd0);
    endtask

    task automatic do_reset(input logic btn);
        RST = 1'b1;
        BUTTON = btn;
        REQ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("rst");
        RST = 1'b0;
    endtask

    // Called right after the acceptance edge; follows words 0..last, then HOLD if last==8.
    task automatic run_seq(input string tag, input logic [23:0] a1, input logic en2,
                           input logic [23:0] a2, input int last);
        int   lat;
        bit   found;
        bit   held;
        logic [15:0] prev;
        lat = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ICAP_CE == 1'b0) found = 1;
            else begin
                step();
                lat++;
            end
        end
        check({tag, "_word0_seen"}, 32'(found), 32'd1);
        if (!found) return;
        check({tag, "_latency_ok"}, 32'(lat <= 2 * (CDIV + 1) + 1), 32'd1);
        for (int w = 0; w <= last; w++) begin
            if (w > 0) begin
                held = 1;
                prev = ICAP_O;
                for (int k = 1; k < 2 * (CDIV + 1); k++) begin
                    step();
                    if (ICAP_O !== prev || ICAP_CE !== 1'b0) held = 0;
                end
                check($sformatf("%s_hold_w%0d", tag, w - 1), 32'(held), 32'd1);
                step();
            end
            check($sformatf("%s_word%0d", tag, w), 32'(ICAP_O), 32'(exp_word(w, a1)));
            check($sformatf("%s_ce_we_w%0d", tag, w), {30'd0, ICAP_CE, ICAP_WRITE}, 32'd0);
            if (en2) begin
                check($sformatf("%s_wrap_word%0d", tag, w), 32'(ICAP_O2),
                      32'(exp_word(w, a2)));
            end
            $display("%s word %0d: ICAP_O=%h", tag, w, ICAP_O);
        end
        if (last == 8) begin
            repeat (2 * (CDIV + 1)) step();
            check({tag, "_hold_ce"}, 32'(ICAP_CE), 32'd1);
            check({tag, "_hold_write"}, 32'(ICAP_WRITE), 32'd1);
            check({tag, "_hold_o"}, 32'(ICAP_O), 32'hFFFF);
            check({tag, "_hold_busy"}, 32'(BUSY), 32'd1);
        end
    endtask

    initial begin
        RST = 1'b1;
        BUTTON = 1'b0;
        REQ = 1'b0;
        IMG_SEL = 4'd0;
        IMG_SEL2 = 4'd0;
        #1;
        check_reset("por");

        // Button held at power-on: image 1 at 020000.
        do_reset(1'b0);
        step();
        check("btn_busy", 32'(BUSY), 32'd1);
        run_seq("btn", 24'h020000, 1'b0, 24'h0, 8);

        // Requests are ignored in HOLD.
        REQ = 1'b1;
        IMG_SEL = 4'd4;
        repeat (6) step();
        check("hold_no_err", 32'(ERR), 32'd0);
        check("hold_still_ce", 32'(ICAP_CE), 32'd1);
        REQ = 1'b0;

        // Button released at reset: IDLE, then reject out-of-range index.
        do_reset(1'b1);
        repeat (2) step();
        check("idle_busy", 32'(BUSY), 32'd0);
        REQ = 1'b1;
        IMG_SEL = 4'd4;
        IMG_SEL2 = 4'd4;
        step();
        REQ = 1'b0;
        check("rej_err", 32'(ERR), 32'd1);
        check("rej_busy", 32'(BUSY), 32'd0);
        step();
        check("rej_err_drop", 32'(ERR), 32'd0);
        check("rej_ce", 32'(ICAP_CE), 32'd1);
        $display("reject: ERR=%b BUSY=%b", ERR, BUSY);

        // Valid request: image 3 -> 060000; wrapping instance image 1 -> 010000.
        REQ = 1'b1;
        IMG_SEL = 4'd3;
        IMG_SEL2 = 4'd1;
        step();
        REQ = 1'b0;
        check("req_busy", 32'(BUSY), 32'd1);
        check("req_wrap_busy", 32'(BUSY2), 32'd1);
        run_seq("req", 24'h060000, 1'b1, 24'h010000, 8);

        // Reset during word 4, then a fresh request runs from word 0.
        do_reset(1'b1);
        step();
        REQ = 1'b1;
        IMG_SEL = 4'd2;
        step();
        REQ = 1'b0;
        run_seq("pre", 24'h040000, 1'b0, 24'h0, 4);
        step();
        RST = 1'b1;
        #1;
        check_reset("async");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        step();
        REQ = 1'b1;
        IMG_SEL = 4'd0;
        step();
        REQ = 1'b0;
        run_seq("post", 24'h000000, 1'b0, 24'h0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
